// File: rtl/score_digit_overlay.sv
// Score digit overlay: draws P1/P2 tens and ones digits from a shared glyph ROM
// into the VGA pixel stream with a fixed two-cycle latency.
module score_digit_overlay #(
    parameter int X_TENS_1 = 205,
    parameter int X_ONES_1 = 260,
    parameter int X_TENS_2 = 390,
    parameter int X_ONES_2 = 445,
    parameter int Y_POS    = 10,
    parameter int DIGIT_W  = 55,
    parameter int DIGIT_H  = 75,
    parameter int ROM_AW   = 16
) (
    input  logic              clk25,
    input  logic              reset,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              blank,
    input  logic              frame_tick,
    input  logic [3:0]        score_1_tens,
    input  logic [3:0]        score_1_ones,
    input  logic [3:0]        score_2_tens,
    input  logic [3:0]        score_2_ones,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [8:0]        rom_data,
    output logic [8:0]        pixel,
    output logic              pixel_on,
    output logic              blank_out
);

    // Box index order doubles as overlap priority: tens1, ones1, tens2, ones2.
    localparam logic [9:0] BOX_LEFT [4] = '{
        10'(X_TENS_1), 10'(X_ONES_1), 10'(X_TENS_2), 10'(X_ONES_2)
    };
    localparam logic [9:0] BOX_RIGHT [4] = '{
        10'(X_TENS_1 + DIGIT_W), 10'(X_ONES_1 + DIGIT_W),
        10'(X_TENS_2 + DIGIT_W), 10'(X_ONES_2 + DIGIT_W)
    };
    localparam logic [9:0] Y_TOP = 10'(Y_POS);
    localparam logic [9:0] Y_BOT = 10'(Y_POS + DIGIT_H);

    localparam logic [ROM_AW-1:0] GLYPH_SIZE = ROM_AW'(DIGIT_W * DIGIT_H);
    localparam logic [ROM_AW-1:0] ROW_PITCH  = ROM_AW'(DIGIT_W);

    // Per-frame snapshot of the scores, indexed in box order.
    logic [3:0] shadow_digit [4];

    logic              in_rows;
    logic [3:0]        box_hit;
    logic              hit;
    logic [1:0]        sel;
    logic [6:0]        row;
    logic [5:0]        col;
    logic [ROM_AW-1:0] glyph_base;
    logic [ROM_AW-1:0] row_offset;
    logic [ROM_AW-1:0] addr_next;

    logic              hit_d1;
    logic              blank_d1;

    // Capture the scores only on the frame tick so a digit never changes mid-frame.
    always_ff @(posedge clk25) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                shadow_digit[k] <= 4'd0;
            end
        end else if (frame_tick) begin
            shadow_digit[0] <= score_1_tens;
            shadow_digit[1] <= score_1_ones;
            shadow_digit[2] <= score_2_tens;
            shadow_digit[3] <= score_2_ones;
        end
    end

    // Per-box hit test; a non-BCD digit suppresses its box entirely.
    always_comb begin
        in_rows = (y >= Y_TOP) && (y < Y_BOT);
        box_hit = '0;
        for (int k = 0; k < 4; k++) begin
            box_hit[k] = !blank && in_rows
                         && (x >= BOX_LEFT[k]) && (x < BOX_RIGHT[k])
                         && (shadow_digit[k] <= 4'd9);
        end
    end

    // Priority select: scanning high to low lets the lowest index win on overlap.
    always_comb begin
        hit = 1'b0;
        sel = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (box_hit[k]) begin
                hit = 1'b1;
                sel = 2'(k);
            end
        end
    end

    // Glyph address = digit base + row * width + column, all within ROM_AW bits.
    always_comb begin
        row        = 7'(y - Y_TOP);
        col        = 6'(x - BOX_LEFT[sel]);
        glyph_base = ROM_AW'(shadow_digit[sel]) * GLYPH_SIZE;
        row_offset = ROM_AW'(row) * ROW_PITCH;
        addr_next  = hit ? (glyph_base + row_offset + ROM_AW'(col)) : '0;
    end

    // Stage 1: register the ROM address together with the hit and blank qualifiers.
    always_ff @(posedge clk25) begin
        if (reset) begin
            rom_addr <= '0;
            hit_d1   <= 1'b0;
            blank_d1 <= 1'b1;
        end else begin
            rom_addr <= addr_next;
            hit_d1   <= hit;
            blank_d1 <= blank;
        end
    end

    // Stage 2: ROM data arrives; a zero glyph pixel is transparent.
    always_ff @(posedge clk25) begin
        if (reset) begin
            pixel     <= 9'd0;
            pixel_on  <= 1'b0;
            blank_out <= 1'b1;
        end else begin
            pixel     <= hit_d1 ? rom_data : 9'd0;
            pixel_on  <= hit_d1 && (rom_data != 9'd0);
            blank_out <= blank_d1;
        end
    end

endmodule

// File: tb/tb_score_digit_overlay.sv
// Self-checking bench for score_digit_overlay: directed steps plus randomized
// traffic compared against a box/arithmetic reference model of the overlay.
module tb_score_digit_overlay;

    logic        clk25 = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x = 10'd210;
    logic [9:0]  y = 10'd20;
    logic        blank = 1'b0;
    logic        frame_tick = 1'b0;
    logic [3:0]  score_1_tens = 4'd0;
    logic [3:0]  score_1_ones = 4'd0;
    logic [3:0]  score_2_tens = 4'd0;
    logic [3:0]  score_2_ones = 4'd0;
    logic [15:0] rom_addr;
    logic [8:0]  rom_data;
    logic [8:0]  pixel;
    logic        pixel_on;
    logic        blank_out;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_shadow [4];
    bit m_prev_hit;
    int m_prev_addr;
    bit m_prev_blank;
    int box_left [4] = '{205, 260, 390, 445};

    always #20 clk25 = ~clk25;

    // Synthetic glyph ROM content; one fixed entry gives a known full-white pixel.
    function automatic logic [8:0] rom_func(input int a);
        if (a == 12375) return 9'h1FF;
        if (a % 5 == 0) return 9'h000;
        return 9'((a * 37 + 11) % 512);
    endfunction

    assign rom_data = rom_func(int'(rom_addr));

    score_digit_overlay dut (
        .clk25        (clk25),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .blank        (blank),
        .frame_tick   (frame_tick),
        .score_1_tens (score_1_tens),
        .score_1_ones (score_1_ones),
        .score_2_tens (score_2_tens),
        .score_2_ones (score_2_ones),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .pixel        (pixel),
        .pixel_on     (pixel_on),
        .blank_out    (blank_out)
    );

    function automatic void model_lookup(input int px, input int py, input bit pb,
                                         output bit h, output int a);
        h = 1'b0;
        a = 0;
        if (!pb && py >= 10 && py < 10 + 75) begin
            for (int k = 0; k < 4; k++) begin
                if (!h && px >= box_left[k] && px < box_left[k] + 55 && m_shadow[k] <= 9) begin
                    h = 1'b1;
                    a = m_shadow[k] * 55 * 75 + (py - 10) * 55 + (px - box_left[k]);
                end
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input bit r, input int px, input int py,
                                 input bit pb, input bit ft);
        bit e_hit;
        int e_addr;
        logic [8:0] e_pixel;
        bit e_on;
        bit e_blank;
        @(negedge clk25);
        reset      = r;
        x          = 10'(px);
        y          = 10'(py);
        blank      = pb;
        frame_tick = ft;
        if (r) begin
            e_hit = 1'b0;
            e_addr = 0;
            e_pixel = 9'd0;
            e_on = 1'b0;
            e_blank = 1'b1;
        end else begin
            model_lookup(px, py, pb, e_hit, e_addr);
            e_pixel = m_prev_hit ? rom_func(m_prev_addr) : 9'd0;
            e_on    = m_prev_hit && (rom_func(m_prev_addr) != 9'd0);
            e_blank = m_prev_blank;
        end
        @(posedge clk25);
        #1;
        checkOutput({tag, "_rom_addr"}, 32'(rom_addr), 32'(e_addr));
        checkOutput({tag, "_pixel"}, 32'(pixel), 32'(e_pixel));
        checkOutput({tag, "_pixel_on"}, 32'(pixel_on), 32'(e_on));
        checkOutput({tag, "_blank_out"}, 32'(blank_out), 32'(e_blank));
        if (r) begin
            for (int k = 0; k < 4; k++) m_shadow[k] = 0;
            m_prev_hit = 1'b0;
            m_prev_addr = 0;
            m_prev_blank = 1'b1;
        end else begin
            m_prev_hit = e_hit;
            m_prev_addr = e_addr;
            m_prev_blank = pb;
            if (ft) begin
                m_shadow[0] = int'(score_1_tens);
                m_shadow[1] = int'(score_1_ones);
                m_shadow[2] = int'(score_2_tens);
                m_shadow[3] = int'(score_2_ones);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) m_shadow[k] = 0;
        m_prev_hit = 1'b0;
        m_prev_addr = 0;
        m_prev_blank = 1'b1;

        $display("[TB] reset held with x,y inside a box");
        for (int i = 0; i < 3; i++) applyStimulus("reset_hold", 1'b1, 210, 20, 1'b0, 1'b0);

        $display("[TB] load scores 3,7 / 0,9 and hit top-left of P1 tens");
        score_1_tens = 4'd3; score_1_ones = 4'd7; score_2_tens = 4'd0; score_2_ones = 4'd9;
        applyStimulus("load", 1'b0, 0, 0, 1'b0, 1'b1);
        applyStimulus("p1t_corner", 1'b0, 205, 10, 1'b0, 1'b0);
        checkOutput("p1t_corner_const", 32'(rom_addr), 32'd12375);
        applyStimulus("p1t_pixel", 1'b0, 600, 300, 1'b0, 1'b0);
        checkOutput("p1t_pixel_const", 32'(pixel), 32'h1FF);

        $display("[TB] P1 ones bottom-right corner and just outside");
        applyStimulus("p1o_corner", 1'b0, 314, 84, 1'b0, 1'b0);
        checkOutput("p1o_corner_const", 32'(rom_addr), 32'd32999);
        applyStimulus("p1o_right_out", 1'b0, 315, 84, 1'b0, 1'b0);
        applyStimulus("p1o_below_out", 1'b0, 314, 85, 1'b0, 1'b0);
        applyStimulus("flush", 1'b0, 0, 0, 1'b0, 1'b0);

        $display("[TB] score change without frame tick is ignored");
        score_1_ones = 4'd8;
        applyStimulus("no_tick", 1'b0, 314, 84, 1'b0, 1'b0);
        checkOutput("no_tick_const", 32'(rom_addr), 32'd32999);
        applyStimulus("tick8", 1'b0, 0, 0, 1'b0, 1'b1);
        applyStimulus("glyph8", 1'b0, 260, 10, 1'b0, 1'b0);
        checkOutput("glyph8_const", 32'(rom_addr), 32'd33000);

        $display("[TB] invalid P2 tens digit draws nothing over its box");
        score_2_tens = 4'd12;
        applyStimulus("tick12", 1'b0, 0, 0, 1'b0, 1'b1);
        for (int py = 10; py < 85; py++) begin
            for (int px = 390; px < 445; px++) begin
                applyStimulus("bad_digit", 1'b0, px, py, 1'b0, 1'b0);
            end
        end

        $display("[TB] blank pattern across a full line");
        for (int px = 0; px < 800; px++) begin
            applyStimulus("blank_line", 1'b0, px, 20, (px >= 640) || ((px & 4) != 0), 1'b0);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit ft;
            r  = ($urandom_range(0, 199) == 0);
            ft = ($urandom_range(0, 39) == 0);
            if (ft) begin
                score_1_tens = 4'($urandom_range(0, 15));
                score_1_ones = 4'($urandom_range(0, 15));
                score_2_tens = 4'($urandom_range(0, 15));
                score_2_ones = 4'($urandom_range(0, 15));
            end
            applyStimulus("random", r, int'($urandom_range(180, 520)), int'($urandom_range(0, 100)),
                          ($urandom_range(0, 7) == 0), ft);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
